// File: rtl/instruction_fetch_if.sv
// Bus between the IF stage and its surroundings (decode, hazard unit, loader).
// The fetch stage uses the slave modport; whoever drives the stage uses master.
interface instruction_fetch_if #(
    parameter int PC_SIZE   = 32,
    parameter int BUS_SIZE  = 32,
    parameter int MEM_WORDS = 256
);
    localparam int AW = $clog2(MEM_WORDS);

    logic                i_enable;
    logic                i_stall;
    logic                i_flush;
    logic                i_next_pc_src;
    logic [PC_SIZE-1:0]  i_next_not_seq_pc;
    logic                i_mem_wr_enable;
    logic [AW-1:0]       i_mem_wr_addr;
    logic [BUS_SIZE-1:0] i_mem_wr_data;
    logic [BUS_SIZE-1:0] o_instruction;
    logic [PC_SIZE-1:0]  o_next_seq_pc;
    logic [PC_SIZE-1:0]  o_pc;
    logic                o_halt;

    modport master (
        output i_enable, i_stall, i_flush, i_next_pc_src, i_next_not_seq_pc,
               i_mem_wr_enable, i_mem_wr_addr, i_mem_wr_data,
        input  o_instruction, o_next_seq_pc, o_pc, o_halt
    );

    modport slave (
        input  i_enable, i_stall, i_flush, i_next_pc_src, i_next_not_seq_pc,
               i_mem_wr_enable, i_mem_wr_addr, i_mem_wr_data,
        output o_instruction, o_next_seq_pc, o_pc, o_halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC register, writable instruction memory,
// next-PC select and the IF/ID pipeline latch.
// Optional HALT detection (32'hFFFF_FFFF stops fetch until reset) is built
// when INSTRUCTION_FETCH_HALT_DETECT_EN is defined.
module instruction_fetch #(
    parameter int PC_SIZE   = 32,
    parameter int BUS_SIZE  = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              i_clk,
    input  logic              i_reset,
    instruction_fetch_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    // Memory contents live outside the reset domain so a loaded program
    // survives reset; it starts out all zeros.
    logic [BUS_SIZE-1:0] mem [MEM_WORDS] = '{default: '0};

    logic [PC_SIZE-1:0]  pc;
    logic [PC_SIZE-1:0]  pc_plus4;
    logic [PC_SIZE-1:0]  next_pc;
    logic [BUS_SIZE-1:0] fetch_word;
    logic [BUS_SIZE-1:0] instr_q;
    logic [PC_SIZE-1:0]  next_seq_q;
    logic                halted;
    logic                advance;

    // Upper PC bits are dropped here, so the word index wraps.
    assign fetch_word = mem[pc[AW+1:2]];
    assign pc_plus4   = pc + PC_SIZE'(4);
    assign next_pc    = bus.i_next_pc_src ? (bus.i_next_not_seq_pc & ~PC_SIZE'(3))
                                          : pc_plus4;
    assign advance    = bus.i_enable & ~bus.i_stall & ~halted;

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    localparam logic [BUS_SIZE-1:0] HALT_WORD = '1;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;
    state_t state, state_next;

    // Run/halted state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_RUN;
        else          state <= state_next;
    end

    // Enter HALTED on an advancing fetch of the HALT word; only reset leaves it.
    // Uses the raw enable/stall rather than advance to keep halted out of its own cone.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:
                if (bus.i_enable && !bus.i_stall && fetch_word == HALT_WORD)
                    state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
        endcase
    end

    assign halted = (state == ST_HALTED);
`else
    assign halted = 1'b0;
`endif

    // Program counter
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)     pc <= '0;
        else if (advance) pc <= next_pc;
    end

    // IF/ID latch; flush wins over stall and halt but not over a low enable
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            instr_q    <= '0;
            next_seq_q <= '0;
        end else if (bus.i_enable && bus.i_flush) begin
            instr_q    <= '0;
            next_seq_q <= pc_plus4;
        end else if (advance) begin
            instr_q    <= fetch_word;
            next_seq_q <= pc_plus4;
        end
    end

    // Loader write port, independent of enable, stall and halt
    always_ff @(posedge i_clk) begin
        if (bus.i_mem_wr_enable) mem[bus.i_mem_wr_addr] <= bus.i_mem_wr_data;
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_next_seq_pc = next_seq_q;
    assign bus.o_pc          = pc;
    assign bus.o_halt        = halted;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;
    localparam int PC_SIZE   = 32;
    localparam int BUS_SIZE  = 32;
    localparam int MEM_WORDS = 256;

    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    instruction_fetch_if #(.PC_SIZE(PC_SIZE), .BUS_SIZE(BUS_SIZE), .MEM_WORDS(MEM_WORDS)) ifc ();

    instruction_fetch #(.PC_SIZE(PC_SIZE), .BUS_SIZE(BUS_SIZE), .MEM_WORDS(MEM_WORDS)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (ifc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en;
        logic        stall;
        logic        flush;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] e_instr;
        logic [31:0] e_nsp;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] en,
                             input logic [31:0] ep, input logic eh);
        check({tag, " instr"}, ifc.o_instruction, ei);
        check({tag, " nsp"},   ifc.o_next_seq_pc, en);
        check({tag, " pc"},    ifc.o_pc, ep);
        check({tag, " halt"},  {31'b0, ifc.o_halt}, {31'b0, eh});
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] data);
        ifc.i_mem_wr_enable = 1'b1;
        ifc.i_mem_wr_addr   = addr;
        ifc.i_mem_wr_data   = data;
        step();
        ifc.i_mem_wr_enable = 1'b0;
    endtask

    task automatic set_ctl(input logic en, input logic stall, input logic flush,
                           input logic src, input logic [31:0] tgt);
        ifc.i_enable          = en;
        ifc.i_stall           = stall;
        ifc.i_flush           = flush;
        ifc.i_next_pc_src     = src;
        ifc.i_next_not_seq_pc = tgt;
    endtask

`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
    localparam logic HALT_EXP = 1'b1;
`else
    localparam logic HALT_EXP = 1'b0;
`endif

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h2001_0005, 32'h4,   32'h4};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h43,  32'h2002_0007, 32'h8,   32'h40};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h1111_0010, 32'h44,  32'h44};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0A,  32'h1111_0011, 32'h48,  32'h8};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1111_0011, 32'h48,  32'h8};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1111_0011, 32'h48,  32'h8};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h3C03_0002, 32'hC,   32'hC};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8,   32'h0043_0020, 32'h10,  32'h8};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,         32'hC,   32'h8};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,         32'hC,   32'hC};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0043_0020, 32'h10,  32'h10};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0043_0020, 32'h10,  32'h10};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3FC, 32'h0043_0020, 32'h10,  32'h10};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h3FC, 32'h0,         32'h14,  32'h3FC};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'hAAAA_00FF, 32'h400, 32'h400};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h2001_0005, 32'h404, 32'h404};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h20,  32'h2002_0007, 32'h408, 32'h20};

        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        ifc.i_mem_wr_enable = 1'b0;
        ifc.i_mem_wr_addr   = '0;
        ifc.i_mem_wr_data   = '0;

        // Reset state, also across a clock edge
        #3;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        check_all("reset_edge", 32'h0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b1;

        // Load program with fetch disabled
        load(8'd0,   32'h2001_0005);
        load(8'd1,   32'h2002_0007);
        load(8'd2,   32'hFFFF_FFFF);
        load(8'd3,   32'h0043_0020);
        load(8'd16,  32'h1111_0010);
        load(8'd17,  32'h1111_0011);
        load(8'd255, 32'hAAAA_00FF);
        check("frozen pc", ifc.o_pc, 32'h0);
        check("frozen instr", ifc.o_instruction, 32'h0);

        // Straight-line run into the HALT word
        ifc.i_enable = 1'b1;
        step(); check_all("run1", 32'h2001_0005, 32'h4, 32'h4, 1'b0);
        step(); check_all("run2", 32'h2002_0007, 32'h8, 32'h8, 1'b0);
        step(); check_all("run3", 32'hFFFF_FFFF, 32'hC, 32'hC, HALT_EXP);
        for (int i = 0; i < 10; i++) begin
            step();
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
            check($sformatf("halted pc %0d", i), ifc.o_pc, 32'hC);
            check($sformatf("halted instr %0d", i), ifc.o_instruction, 32'hFFFF_FFFF);
            check($sformatf("halted flag %0d", i), {31'b0, ifc.o_halt}, 32'h1);
`else
            check($sformatf("nohalt pc %0d", i), ifc.o_pc, 32'hC + 32'(4 * (i + 1)));
            check($sformatf("nohalt flag %0d", i), {31'b0, ifc.o_halt}, 32'h0);
`endif
        end
`ifdef INSTRUCTION_FETCH_HALT_DETECT_EN
        ifc.i_flush = 1'b1;
        step();
        ifc.i_flush = 1'b0;
        check_all("halt_flush", 32'h0, 32'h10, 32'hC, 1'b1);
`endif

        // Reset clears halt; replace the HALT word and run the directed table
        i_reset = 1'b0;
        #2;
        check_all("reset2", 32'h0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b1;
        ifc.i_enable = 1'b0;
        load(8'd2, 32'h3C03_0002);

        for (int i = 0; i < 17; i++) begin
            set_ctl(vecs[i].en, vecs[i].stall, vecs[i].flush, vecs[i].src, vecs[i].tgt);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_nsp, vecs[i].e_pc, 1'b0);
        end
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-run at PC 0x20, then restart from 0
        #2;
        i_reset = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        #2;
        i_reset = 1'b1;
        step();
        check_all("restart", 32'h2001_0005, 32'h4, 32'h4, 1'b0);

        // Write to the word being fetched: fetch sees old data, later fetch sees new
        ifc.i_mem_wr_enable = 1'b1;
        ifc.i_mem_wr_addr   = 8'd1;
        ifc.i_mem_wr_data   = 32'h5555_AAAA;
        step();
        ifc.i_mem_wr_enable = 1'b0;
        check_all("wr_old", 32'h2002_0007, 32'h8, 32'h8, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
        step();
        check_all("wr_branch", 32'h3C03_0002, 32'hC, 32'h4, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_all("wr_new", 32'h5555_AAAA, 32'h8, 32'h8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
